jk_cmd_sequencer: RTL
=====================

# jk_cmd_sequencer

Command-driven stimulus stage that sits directly upstream of a `jkff` J-K flip-flop and drives its `j`/`k` inputs. Commands carry an operation (hold/reset/set/toggle) and a repeat count. They are accepted over a valid/ready handshake, buffered in a small FIFO, and issued one `{j,k}` pair per clock. A shadow model of the downstream flip-flop's state is maintained so the consumer's `q` can be checked cycle-for-cycle.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 4: repeat-count width; a command issues `count+1` cycles.

- `clk`  in  1  rising-edge clock, shared with the downstream `jkff`.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command; equals `!full`.
- `cmd_op`  in  2  `{j,k}` encoding: 00 hold, 01 reset, 10 set, 11 toggle.
- `cmd_count`  in  CNT_W  repeat count N; the op is issued N+1 consecutive cycles.
- `abort`  in  1  synchronous flush of the FIFO and the active command.
- `j`, `k`  out  1 each  registered drive to the downstream flip-flop.
- `busy`  out  1  a command is being issued (state ISSUE).
- `expected_q`  out  1  shadow of the downstream `q` after it samples `j`/`k`.
- `fill`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push when `cmd_valid && cmd_ready` at a rising edge. A push while full is not accepted, even if a pop occurs on the same edge.
- FSM states:
  - **IDLE**: `j=k=0`.
  - **ISSUE**: `{j,k}` = active op; the `remaining` counter counts down.
- IDLE→ISSUE: at any edge with the FIFO non-empty. Pop, load `{j,k}` ← op and `remaining` ← count.
- ISSUE with `remaining>0`: decrement and hold `{j,k}`.
- ISSUE with `remaining==0`:
  - FIFO non-empty: pop the next command and load it on the same edge, with no bubble.
  - FIFO empty: go to IDLE and set `j=k=0`.
- Simultaneous push and pop on a non-full FIFO: both occur and `fill` is unchanged.
- Push into an empty FIFO while IDLE: the entry is popped at the next edge, never the same edge.
- Shadow model: at every edge, `expected_q` ← next-state(`expected_q`, current registered `j`,`k`).
  - 00 keeps the value; 01 gives 0; 10 gives 1; 11 inverts.
  - This is exactly what the downstream flop computes from the same registered values on the same edge.
- `abort` high at an edge:
  - Empties the FIFO, forces IDLE and sets `j=k=0`.
  - A push on the same edge is discarded.
  - `expected_q` still applies the pre-abort `{j,k}` on that edge.
- Count arithmetic is unsigned CNT_W. `cmd_count = 2^CNT_W−1` issues 2^CNT_W cycles, with no overflow.

## Timing
- Reset values (asynchronous on `rst_n` low): FSM IDLE; `j=0`, `k=0`, `busy=0`, `expected_q=0` (matches the `jkff` initial state); FIFO empty, `fill=0`; `cmd_ready=1`.
- No push is accepted while `rst_n` is low.
- Reset mid-command drops the command and all queued entries immediately.
- Latency, empty and idle case:
  - Command accepted at edge E0; the pop occurs at E1.
  - `{j,k}` and `busy` change just after E1.
  - The downstream flop and `expected_q` reflect the op at E2.
- A command occupies exactly `count+1` cycles of `{j,k}`. Back-to-back commands produce contiguous ops.
- `busy` is registered. It is high for exactly the cycles in which a non-IDLE `{j,k}` is driven from a command, including hold ops.
- `cmd_ready` and `fill` are combinational from the FIFO pointers. `cmd_ready` rises the cycle after a pop from full.

## Structure
- Package `jk_pkg` holds:
  - `jk_op_t` enum: `JK_HOLD=2'b00`, `JK_RESET=2'b01`, `JK_SET=2'b10`, `JK_TOGGLE=2'b11`.
  - State enum `{IDLE, ISSUE}`.
  - Function `jk_next(q, op)`, shared by the sequencer shadow model and the bench scoreboard.
- One sub-module, `jk_cmd_fifo`:
  - Parameterised by `DEPTH` and width `2+CNT_W`.
  - Pointers carry an extra wrap bit for the full/empty distinction.
  - Exposes `full`, `empty` and `fill`, and takes a synchronous `flush` input.
- The top level contains the FSM, the `remaining` counter, the `j`/`k` registers and `expected_q`.

## Test plan
- Reset then push SET count=2 at E0 → `j,k=10` for E1–E3, then 00. `expected_q`=1 from E2. `busy` high for 3 cycles.
- Push TOGGLE count=3 from `q=0` → `expected_q` sequence 1,0,1,0. A `jkff` instance connected downstream matches `expected_q` every cycle.
- Hold `cmd_valid` with the consumer busy on a long command → `fill` reaches 4, `cmd_ready`=0, and a 5th push is not accepted. After one pop, `cmd_ready`=1 on the next cycle.
- Queue SET c=0, RESET c=0, TOGGLE c=1 → `{j,k}` = 10,01,11,11 on consecutive cycles with no bubble. `expected_q` = 1,0,1,0.
- `abort` asserted mid-TOGGLE with 2 entries queued → the next cycle has `j=k=0`, `fill=0`, `busy=0`, and `expected_q` includes the final toggle.
- Pull `rst_n` low mid-command between edges → `j`, `k`, `busy` and `expected_q` go to 0 immediately. After release, the first new command issues with E0→E1 latency.

Source files
------------

// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared types and the J-K next-state rule for the command sequencer.
// The bench scoreboard uses the same next-state rule.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } jk_state_t;

   function automatic logic jk_next(input logic q, input jk_op_t op);
      logic q_nxt;
      case (op)
         JK_RESET:  q_nxt = 1'b0;
         JK_SET:    q_nxt = 1'b1;
         JK_TOGGLE: q_nxt = ~q;
         default:   q_nxt = q;
      endcase
      return q_nxt;
   endfunction

endpackage

// File: rtl/jk_cmd_sequencer_fifo.sv
// Command FIFO for the J-K sequencer. Pointers carry one extra wrap bit
// so full and empty are distinguishable; flush clears both pointers.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; it is only read when the pointers say it is valid.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign fill  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command-driven j/k driver for a downstream J-K flop, with a shadow of
// that flop's q so the consumer can be checked cycle for cycle.
//
//   state | meaning
//   IDLE  | no command active, j=k=0
//   ISSUE | active op driven on {j,k}; remaining counts down to 0
import jk_pkg::*;

module jk_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [CNT_W-1:0]         cmd_count,
   input  logic                     abort,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     expected_q,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int EW = 2 + CNT_W;

   jk_state_t        r_state;
   jk_state_t        w_state_nxt;
   jk_op_t           r_jk;
   jk_op_t           w_jk_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic             r_exp_q;
   logic             w_pop;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [EW-1:0]    w_fifo_rdata;
   jk_op_t           w_head_op;
   logic [CNT_W-1:0] w_head_count;

   // Abort discards a push on the same edge as well as the queued entries.
   assign w_push    = cmd_valid && !w_full && !abort;
   assign cmd_ready = !w_full;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .push  (w_push),
      .pop   (w_pop),
      .wdata ({cmd_op, cmd_count}),
      .rdata (w_fifo_rdata),
      .full  (w_full),
      .empty (w_empty),
      .fill  (fill)
   );

   assign w_head_op    = jk_op_t'(w_fifo_rdata[EW-1 -: 2]);
   assign w_head_count = w_fifo_rdata[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_jk        <= JK_HOLD;
         r_remaining <= '0;
         r_exp_q     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_jk        <= w_jk_nxt;
         r_remaining <= w_remaining_nxt;
         r_exp_q     <= jk_next(r_exp_q, r_jk);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_jk_nxt        = r_jk;
      w_remaining_nxt = r_remaining;
      w_pop           = 1'b0;
      if (abort) begin
         w_state_nxt     = IDLE;
         w_jk_nxt        = JK_HOLD;
         w_remaining_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  w_pop           = 1'b1;
                  w_state_nxt     = ISSUE;
                  w_jk_nxt        = w_head_op;
                  w_remaining_nxt = w_head_count;
               end
            end
            ISSUE: begin
               if (r_remaining != '0) begin
                  w_remaining_nxt = r_remaining - 1'b1;
               end else if (!w_empty) begin
                  // Back-to-back load keeps the op stream contiguous.
                  w_pop           = 1'b1;
                  w_jk_nxt        = w_head_op;
                  w_remaining_nxt = w_head_count;
               end else begin
                  w_state_nxt = IDLE;
                  w_jk_nxt    = JK_HOLD;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_jk_nxt    = JK_HOLD;
            end
         endcase
      end
   end

   always_comb begin
      busy       = (r_state == ISSUE);
      j          = r_jk[1];
      k          = r_jk[0];
      expected_q = r_exp_q;
   end

endmodule
